// File: rtl/mld_7_4_encoder.sv
// mld_7_4_encoder: serial systematic (7,4) cyclic encoder, g(x) = 1 + x + x^3.
// Message bits pass straight to out while the LFSR divides; parity is then shifted out MSB first.
module mld_7_4_encoder (
   input  logic clk,
   input  logic reset,
   output logic out,
   input  logic information_bit,
   input  logic sel
);
   logic [2:0] r_q, r_d;
   logic       f;
   // r_q[0] = x^0 coefficient, r_q[2] = x^2 coefficient
   always_comb begin
      f   = information_bit ^ r_q[2];
      r_d = sel ? {r_q[1], r_q[0], 1'b0} : {r_q[1], r_q[0] ^ f, f};
      out = reset ? 1'b0 : (sel ? r_q[2] : information_bit);
   end
   always_ff @(posedge clk) r_q <= reset ? 3'b000 : r_d;
endmodule

// File: tb/tb_mld_7_4_encoder.sv
// tb_mld_7_4_encoder: polynomial-remainder model checked every cycle, plus literal codeword checks.
module tb_mld_7_4_encoder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sel = 1'b0;
   logic information_bit = 1'b0;
   logic out;
   int   checks = 0;
   int   errors = 0;
   logic started = 1'b0;
   logic [2:0] m_p;
   logic [2:0] par_tab [16] = '{3'b000, 3'b011, 3'b110, 3'b101, 3'b111, 3'b100, 3'b001, 3'b010,
                                3'b101, 3'b110, 3'b011, 3'b000, 3'b010, 3'b001, 3'b100, 3'b111};

   mld_7_4_encoder dut (
      .clk(clk),
      .reset(reset),
      .out(out),
      .information_bit(information_bit),
      .sel(sel)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] pmod(input logic [6:0] v);
      logic [6:0] t;
      t = v;
      for (int i = 6; i >= 3; i--)
         if (t[i]) t = t ^ (7'b0001011 << (i - 3));
      return t[2:0];
   endfunction

   // remainder model: message step computes (x*p + b*x^3) mod g; parity step is a plain shift
   always @(posedge clk)
      if (reset) m_p <= 3'b000;
      else if (sel) m_p <= {m_p[1:0], 1'b0};
      else m_p <= pmod({3'b000, m_p, 1'b0} ^ {3'b000, information_bit, 3'b000});

   always @(negedge clk)
      if (started) begin
         logic exp_o;
         exp_o = reset ? 1'b0 : (sel ? m_p[2] : information_bit);
         checks++;
         if (out !== exp_o) begin
            errors++;
            $display("FAIL cycle_out t=%0t: out=%b expected=%b (sel=%b info=%b reset=%b)",
                     $time, out, exp_o, sel, information_bit, reset);
         end
      end

   task automatic chk(input string name, input int got, input int exp_v);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp_v);
      end
   endtask

   task automatic step(input logic r, input logic s, input logic b, output logic o);
      reset = r;
      sel = s;
      information_bit = b;
      @(negedge clk);
      o = out;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      logic o;
      step(1'b1, 1'b1, 1'b1, o);
      chk("reset_out", o, 0);
   endtask

   task automatic codeword(input logic [3:0] m, input int npar, output logic [6:0] w, output logic [3:0] extra);
      logic o;
      w = '0;
      extra = '0;
      for (int i = 3; i >= 0; i--) begin
         step(1'b0, 1'b0, m[i], o);
         w = {w[5:0], o};
      end
      for (int i = 0; i < npar; i++) begin
         step(1'b0, 1'b1, 1'b0, o);
         if (i < 3) w = {w[5:0], o};
         else extra = {extra[2:0], o};
      end
   endtask

   initial begin
      logic [6:0] w;
      logic [3:0] ex;
      logic o;
      #1;
      started = 1'b1;
      do_reset();
      codeword(4'b1000, 3, w, ex);
      chk("cw_1000", w, 7'b1000101);
      do_reset();
      codeword(4'b0110, 3, w, ex);
      chk("cw_0110", w, 7'b0110001);
      do_reset();
      codeword(4'b1011, 3, w, ex);
      chk("cw_1011_g", w, 7'b1011000);
      do_reset();
      codeword(4'b0000, 3, w, ex);
      chk("cw_zero", w, 7'b0000000);
      // short message 0,1,1 then four parity cycles and a zero tail
      do_reset();
      begin
         logic [6:0] sw;
         sw = '0;
         for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, (i != 0), o);
            sw = {sw[5:0], o};
         end
         for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, o);
            sw = {sw[5:0], o};
         end
         chk("short_msg", sw, 7'b0111010);
         for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, o);
            chk("zero_tail", o, 0);
         end
      end
      // abort mid-codeword with reset, then a clean codeword
      do_reset();
      step(1'b0, 1'b0, 1'b1, o);
      step(1'b0, 1'b0, 1'b1, o);
      step(1'b1, 1'b0, 1'b1, o);
      chk("abort_reset_out", o, 0);
      codeword(4'b1000, 3, w, ex);
      chk("after_abort", w, 7'b1000101);
      // all 16 messages against the literal parity table and divisibility by g
      for (int m = 0; m < 16; m++) begin
         logic [3:0] mm;
         mm = 4'(m);
         chk("model_table", pmod({mm, 3'b000}), par_tab[m]);
         do_reset();
         codeword(mm, 3, w, ex);
         chk("exh_table", w, {mm, par_tab[m]});
         chk("exh_divisible", pmod(w), 0);
      end
      // no reset between codewords: zero-flushed register starts clean
      do_reset();
      codeword(4'b1101, 4, w, ex);
      codeword(4'b0011, 3, w, ex);
      chk("back_to_back", w, {4'b0011, par_tab[3]});
      // random sel/info/reset traffic, checked cycle by cycle against the model
      for (int i = 0; i < 3000; i++)
         step(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom), o);
      started = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mld_7_4_encoder.md
MLD_7_4_ENCODER -- requirements
Module: MLD_7_4_encoder

Interface
REQ-001 Parameters: none; code fixed as (7,4) cyclic, generator g(x) = 1 + x + x^3.
REQ-002 Port order: clk, reset, out, information_bit, sel.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high; clears state on a rising clk edge.
REQ-005 out  output  1  serial codeword bit sent to channel.
REQ-006 information_bit  input  1  serial message bit, highest-degree coefficient first.
REQ-007 sel  input  1  0 = message phase, 1 = parity phase.

Function
REQ-008 State: 3-bit parity register r0, r1, r2, holding coefficients of x^0, x^1, x^2; no other state.
REQ-009 Message phase (sel=0), each edge: f = information_bit XOR r2; r0 <= f; r1 <= r0 XOR f; r2 <= r1.
REQ-010 Message phase: out = information_bit, combinational, same cycle (systematic output).
REQ-011 Parity phase (sel=1), each edge: feedback gated to 0; r0 <= 0; r1 <= r0; r2 <= r1.
REQ-012 Parity phase: out = r2, combinational; parity emitted p2, p1, p0 on consecutive cycles.
REQ-013 After 4 message cycles, the register holds p(x) = x^3*m(x) mod g(x); codeword = 4 message bits followed by 3 parity bits.
REQ-014 Block does not count bits; the controller drives sel=0 for exactly 4 cycles, then sel=1 for 3 cycles.
REQ-015 sel held at 1 beyond 3 cycles: register keeps shifting in zeros; out = 0 from the 4th parity cycle onward.
REQ-016 Fewer or more than 4 message cycles: no error; the register simply holds the remainder of the bits actually shifted in.
REQ-017 sel may change on any cycle; the new value takes effect on out combinationally and on the next edge.
REQ-018 No internal clearing between codewords; a new codeword requires reset, or all-zero register after 3 parity shifts (REQ-015).

Reset
REQ-019 reset=1 at rising edge: r0=r1=r2=0; reset has priority over sel and information_bit.
REQ-020 While reset=1, out = 0 regardless of sel and information_bit.
REQ-021 Reset asserted mid-codeword aborts it; the first edge after deassertion resumes normal operation from the all-zero state.

Verification
REQ-022 Reset, then sel=0 with bits 1,0,0,0, then sel=1 for 3 cycles -> out = 1,0,0,0,1,0,1 (parity 101).
REQ-023 Reset, then sel=0 with bits 0,1,1,0, then sel=1 for 3 cycles -> out = 0,1,1,0,0,0,1; register after message = (r0,r1,r2)=(1,0,0).
REQ-024 Reset, then sel=0 with bits 1,0,1,1 (m = g) -> parity 0,0,0; all-zero message -> codeword all zeros.
REQ-025 Reset, then sel=0 with bits 0,1,1, then sel=1 for 4 cycles with information_bit=0 -> out = 0,1,1,1,0,1,0; out stays 0 thereafter.
REQ-026 Assert reset after 2 message bits of 1,1 -> out = 0 during reset; register = 000; then 1,0,0,0 + 3 parity cycles reproduces REQ-022.
REQ-027 Exhaustive: all 16 messages -> every 7-bit output is divisible by g(x) and matches a reference table.
